riscv_decode_stage: RTL and testbench

- Instruction decode (ID) stage of the RV32I pipeline, directly downstream of fetch.
- Accepts a raw 32-bit instruction and its PC over a valid/ready handshake and splits the fields.
- Builds the type-specific sign-extended immediate and reads operands from an integrated 32x32 register file.
- Presents a registered riscv_pkg::decoded_instr_t to the execute stage over a second valid/ready handshake.
- Owns the architectural register file; its write port is driven by the writeback stage.

---
 rtl/riscv_decode_stage.sv | 161 ++++++++++++++++
 tb/tb_riscv_decode_stage.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/riscv_decode_stage.sv
// rtl/riscv_decode_stage.sv - RV32I decode stage with integrated register file (option: DECODE_WB_BYPASS_EN)
package riscv_pkg;
  typedef enum logic [6:0] {
    LUI     = 7'b0110111,
    AUIPC   = 7'b0010111,
    JAL     = 7'b1101111,
    JALR    = 7'b1100111,
    BRANCH  = 7'b1100011,
    LOAD    = 7'b0000011,
    STORE   = 7'b0100011,
    REG_IMM = 7'b0010011,
    REG_REG = 7'b0110011
  } opcode_t;

  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [11:0] imm;
    logic [31:0] imm_extended;
    logic [31:0] reg_A;
    logic [31:0] reg_B;
    logic [31:0] pc;
  } decoded_instr_t;
endpackage

module riscv_decode_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int ADDR = 5
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [31:0]                        in_instr,
  input  logic [XLEN-1:0]                    in_pc,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$bits(decoded_instr_t)-1:0]  out_decoded,
  output logic                               out_illegal,
  input  logic                               wb_en,
  input  logic [ADDR-1:0]                    wb_rd,
  input  logic [XLEN-1:0]                    wb_data
);

  logic [XLEN-1:0] rf [2**ADDR];

  decoded_instr_t dec_q, dec_d;
  logic           valid_q, illegal_q, illegal_d;
  logic           xfer, wb_hit;
  logic           use_rd, use_rs1, use_rs2;
  logic [31:0]    imm_ext;
  logic [4:0]     rd_sel, rs1_sel, rs2_sel;
  logic [XLEN-1:0] op_a, op_b;

  assign in_ready = !valid_q || out_ready;
  assign xfer     = in_valid && in_ready;
  assign wb_hit   = wb_en && (wb_rd != '0);

  // Instruction format classification drives both field gating and immediate shape.
  always_comb begin
    use_rd    = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    imm_ext   = '0;
    illegal_d = 1'b0;
    case (in_instr[6:0])
      REG_REG: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      REG_IMM, LOAD, JALR: begin
        use_rd  = 1'b1;
        use_rs1 = 1'b1;
        imm_ext = {{20{in_instr[31]}}, in_instr[31:20]};
      end
      STORE: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_ext = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      end
      BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
        imm_ext = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                   in_instr[30:25], in_instr[11:8], 1'b0};
      end
      LUI, AUIPC: begin
        use_rd  = 1'b1;
        imm_ext = {in_instr[31:12], 12'h000};
      end
      JAL: begin
        use_rd  = 1'b1;
        imm_ext = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                   in_instr[20], in_instr[30:21], 1'b0};
      end
      default: illegal_d = 1'b1;
    endcase
  end

  assign rd_sel  = use_rd  ? in_instr[11:7]  : 5'd0;
  assign rs1_sel = use_rs1 ? in_instr[19:15] : 5'd0;
  assign rs2_sel = use_rs2 ? in_instr[24:20] : 5'd0;

`ifdef DECODE_WB_BYPASS_EN
  // A writeback landing in the same cycle is forwarded so the captured operand is never stale.
  assign op_a = (wb_hit && (wb_rd == rs1_sel)) ? wb_data : rf[rs1_sel];
  assign op_b = (wb_hit && (wb_rd == rs2_sel)) ? wb_data : rf[rs2_sel];
`else
  assign op_a = rf[rs1_sel];
  assign op_b = rf[rs2_sel];
`endif

  always_comb begin
    dec_d              = '0;
    dec_d.opcode       = in_instr[6:0];
    dec_d.funct3       = in_instr[14:12];
    dec_d.funct7       = in_instr[31:25];
    dec_d.rd           = rd_sel;
    dec_d.rs1          = rs1_sel;
    dec_d.rs2          = rs2_sel;
    dec_d.imm          = imm_ext[11:0];
    dec_d.imm_extended = imm_ext;
    dec_d.reg_A        = op_a;
    dec_d.reg_B        = op_b;
    dec_d.pc           = in_pc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      illegal_q <= 1'b0;
      dec_q     <= '0;
      for (int i = 0; i < 2**ADDR; i++) rf[i] <= '0;
    end else begin
      if (flush) begin
        valid_q <= 1'b0;
      end else if (xfer) begin
        valid_q   <= 1'b1;
        dec_q     <= dec_d;
        illegal_q <= illegal_d;
      end else if (out_ready) begin
        valid_q <= 1'b0;
      end
      // x0 is never written, so its reset value keeps it reading zero.
      if (wb_hit) rf[wb_rd] <= wb_data;
    end
  end

  assign out_valid   = valid_q;
  assign out_decoded = dec_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_riscv_decode_stage.sv
// tb/tb_riscv_decode_stage.sv - self-checking bench for riscv_decode_stage
module tb_riscv_decode_stage;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready, out_illegal;
  logic [31:0] in_instr, in_pc, wb_data;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [$bits(decoded_instr_t)-1:0] out_decoded;
  decoded_instr_t obs;

  assign obs = out_decoded;

  riscv_decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_decoded(out_decoded),
    .out_illegal(out_illegal),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;

  logic [31:0]    m_rf [32];
  logic           m_valid;
  logic           m_ill;
  decoded_instr_t m_dec;

  task automatic chk(input string tag, input logic [255:0] o, input logic [255:0] e);
    total_cnt++;
    assert (o === e) begin
      pass_cnt++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reference decode from the instruction-format rules; fmt: 0=R 1=I 2=S 3=B 4=U 5=J -1=illegal
  function automatic decoded_instr_t ref_dec(input logic [31:0] ins, input logic [31:0] pc,
                                             input logic we, input logic [4:0] wr,
                                             input logic [31:0] wd, output logic ill);
    decoded_instr_t d;
    int fmt;
    logic [31:0] sx;
    case (ins[6:0])
      7'b0110011:                         fmt = 0;
      7'b0010011, 7'b0000011, 7'b1100111: fmt = 1;
      7'b0100011:                         fmt = 2;
      7'b1100011:                         fmt = 3;
      7'b0110111, 7'b0010111:             fmt = 4;
      7'b1101111:                         fmt = 5;
      default:                            fmt = -1;
    endcase
    ill = (fmt < 0);
    d = '0;
    d.opcode = ins[6:0];
    d.funct3 = ins[14:12];
    d.funct7 = ins[31:25];
    d.pc     = pc;
    d.rd     = (fmt == 0 || fmt == 1 || fmt == 4 || fmt == 5) ? ins[11:7]  : 5'd0;
    d.rs1    = (fmt >= 0 && fmt <= 3) ? ins[19:15] : 5'd0;
    d.rs2    = (fmt == 0 || fmt == 2 || fmt == 3) ? ins[24:20] : 5'd0;
    case (fmt)
      1: sx = $signed(ins) >>> 20;
      2: sx = $signed({ins[31:25], ins[11:7], 20'd0}) >>> 20;
      3: sx = $signed({ins[31], ins[7], ins[30:25], ins[11:8], 20'd0}) >>> 19;
      4: sx = ins & 32'hFFFF_F000;
      5: sx = $signed({ins[31], ins[19:12], ins[20], ins[30:21], 12'd0}) >>> 11;
      default: sx = 32'd0;
    endcase
    d.imm_extended = sx;
    d.imm = sx[11:0];
    d.reg_A = m_rf[d.rs1];
    d.reg_B = m_rf[d.rs2];
`ifdef DECODE_WB_BYPASS_EN
    if (we && wr != 0 && wr == d.rs1) d.reg_A = wd;
    if (we && wr != 0 && wr == d.rs2) d.reg_B = wd;
`endif
    return d;
  endfunction

  task automatic cycle(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl, input logic we,
                       input logic [4:0] wr, input logic [31:0] wd);
    decoded_instr_t nd;
    logic nill, xfer;
    in_valid = v; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd;
    @(negedge clk);
    chk("in_ready", in_ready, !m_valid || ordy);
    chk("out_valid", out_valid, m_valid);
    if (m_valid) begin
      chk("out_decoded", out_decoded, m_dec);
      chk("out_illegal", out_illegal, m_ill);
    end
    xfer = v && (!m_valid || ordy);
    nd = ref_dec(ins, pc, we, wr, wd, nill);
    if (fl) m_valid = 1'b0;
    else if (xfer) begin
      m_valid = 1'b1; m_dec = nd; m_ill = nill;
    end else if (ordy) m_valid = 1'b0;
    if (we && wr != 0) m_rf[wr] = wd;
    @(posedge clk);
    #1;
  endtask

  logic [6:0] legal_ops [9];
  logic [31:0] r_ins;

  initial begin
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                  7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
    m_valid = 1'b0; m_ill = 1'b0; m_dec = '0;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0;
    out_ready = 1'b1; wb_en = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_out_decoded", out_decoded, '0);
    chk("reset_out_illegal", out_illegal, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;

    // addi x5,x0,-1
    cycle(1, 32'hFFF00293, 32'h100, 1, 0, 0, 0, 0);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_opcode", obs.opcode, 7'b0010011);
    chk("addi_rd", obs.rd, 5'd5);
    chk("addi_rs1", obs.rs1, 5'd0);
    chk("addi_imm", obs.imm, 12'hFFF);
    chk("addi_immx", obs.imm_extended, 32'hFFFF_FFFF);
    chk("addi_regA", obs.reg_A, 32'd0);
    chk("addi_pc", obs.pc, 32'h100);

    // sw x6,8(x2) after writing x2 and x6
    cycle(0, 0, 0, 1, 0, 1, 5'd2, 32'h1000);
    cycle(0, 0, 0, 1, 0, 1, 5'd6, 32'hDEADBEEF);
    cycle(1, 32'h00612423, 32'h104, 1, 0, 0, 0, 0);
    chk("sw_rd", obs.rd, 5'd0);
    chk("sw_rs1", obs.rs1, 5'd2);
    chk("sw_rs2", obs.rs2, 5'd6);
    chk("sw_immx", obs.imm_extended, 32'd8);
    chk("sw_regA", obs.reg_A, 32'h1000);
    chk("sw_regB", obs.reg_B, 32'hDEADBEEF);

    // beq x1,x2,-4
    cycle(1, 32'hFE208EE3, 32'h108, 1, 0, 0, 0, 0);
    chk("beq_immx", obs.imm_extended, 32'hFFFF_FFFC);
    chk("beq_funct3", obs.funct3, 3'b000);
    chk("beq_rd", obs.rd, 5'd0);

    // stall for three cycles with a pending instruction, then release
    cycle(1, 32'h00100093, 32'h10C, 0, 0, 0, 0, 0);
    chk("stall_in_ready", in_ready, 1'b0);
    cycle(1, 32'h00100093, 32'h10C, 0, 0, 0, 0, 0);
    cycle(1, 32'h00100093, 32'h10C, 0, 0, 0, 0, 0);
    chk("stall_hold_pc", obs.pc, 32'h108);
    cycle(1, 32'h00100093, 32'h10C, 1, 0, 0, 0, 0);
    chk("release_pc", obs.pc, 32'h10C);
    cycle(0, 0, 0, 1, 0, 0, 0, 0);
    chk("no_dup_valid", out_valid, 1'b0);

    // flush while output valid and input offered; also try writing x0
    cycle(1, 32'h00200113, 32'h110, 1, 0, 0, 0, 0);
    cycle(1, 32'h00300193, 32'h114, 1, 1, 1, 5'd0, 32'd5);
    chk("flush_valid", out_valid, 1'b0);
    cycle(1, 32'h000000B3, 32'h118, 1, 0, 0, 0, 0);
    chk("x0_regA", obs.reg_A, 32'd0);
    chk("after_flush_pc", obs.pc, 32'h118);

    // same-cycle writeback to x5 and add x1,x5,x0
    cycle(0, 0, 0, 1, 0, 1, 5'd5, 32'h55);
    cycle(1, 32'h000280B3, 32'h11C, 1, 0, 1, 5'd5, 32'd7);
`ifdef DECODE_WB_BYPASS_EN
    chk("bypass_regA", obs.reg_A, 32'd7);
`else
    chk("nobypass_regA", obs.reg_A, 32'h55);
`endif

    // illegal opcode passes through with zeroed register fields
    cycle(1, 32'hFFFFF07F, 32'h120, 1, 0, 0, 0, 0);
    chk("illegal_flag", out_illegal, 1'b1);
    chk("illegal_immx", obs.imm_extended, 32'd0);

    for (int n = 0; n < 400; n++) begin
      r_ins = $urandom;
      if ($urandom_range(0, 9) != 0) r_ins[6:0] = legal_ops[$urandom_range(0, 8)];
      cycle($urandom_range(0, 3) != 0, r_ins, $urandom, $urandom_range(0, 9) < 7,
            $urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), $urandom);
    end
    cycle(0, 0, 0, 1, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
